// File: rtl/uart_frame_arbiter_pkg.sv
// rtl/uart_frame_arbiter_pkg.sv - shared constants, types and frame byte builder (option: UART_ARB_CHECKSUM_EN)
package uart_frame_arbiter_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef UART_ARB_CHECKSUM_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    KIND_REG   = 2'b00,
    KIND_ALU   = 2'b01,
    KIND_INST  = 2'b10,
    KIND_OTHER = 2'b11
  } kind_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    kind_t       kind;
    logic [4:0]  addr;
    logic [31:0] data;
  } record_t;

  // Byte idx of the frame for a latched record; header packs kind/addr with a zero LSB.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx, input record_t rec);
    logic [7:0] hdr;
    hdr = {rec.kind, rec.addr, 1'b0};
    case (idx)
      3'd0:    frame_byte = SYNC_BYTE;
      3'd1:    frame_byte = hdr;
      3'd2:    frame_byte = rec.data[31:24];
      3'd3:    frame_byte = rec.data[23:16];
      3'd4:    frame_byte = rec.data[15:8];
      3'd5:    frame_byte = rec.data[7:0];
`ifdef UART_ARB_CHECKSUM_EN
      3'd6:    frame_byte = hdr ^ rec.data[31:24] ^ rec.data[23:16] ^ rec.data[15:8] ^ rec.data[7:0];
`endif
      default: frame_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uart_frame_arbiter_if.sv
// rtl/uart_frame_arbiter_if.sv - record request bus and UART byte port
interface uart_frame_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [2*NUM_REQ-1:0]  req_kind;
  logic [5*NUM_REQ-1:0]  req_addr;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  busy;
  logic [ID_W-1:0]       grant_id;

  // Producer/transmitter side
  modport master (
    output req_valid, req_kind, req_addr, req_data, tx_ready,
    input  req_ready, tx_data, tx_valid, busy, grant_id
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_kind, req_addr, req_data, tx_ready,
    output req_ready, tx_data, tx_valid, busy, grant_id
  );
endinterface

// File: rtl/uart_frame_arbiter_rr_arbiter.sv
// rtl/uart_frame_arbiter_rr_arbiter.sv - combinational round-robin grant from rr_ptr upward with wrap
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);
  int idx;

  // First valid requester at or after rr_ptr; a single subtract wraps since idx < 2*NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req_valid[ID_W'(idx)]) begin
        any_req              = 1'b1;
        grant[ID_W'(idx)]    = 1'b1;
        grant_idx            = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/uart_frame_arbiter.sv
// rtl/uart_frame_arbiter.sv - round-robin debug record to UART byte frame scheduler
module uart_frame_arbiter
  import uart_frame_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int GAP_CYCLES = 16,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input logic                 clk,
  input logic                 resetn,
  uart_frame_arbiter_if.slave bus
);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id_q;
  logic [IDX_W-1:0]   byte_idx;
  logic [GAP_W-1:0]   gap_cnt;
  record_t            rec;
  record_t            sel_rec;
  logic [7:0]         tx_data_q;
  logic               tx_valid_q;
  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_idx;
  logic               any_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .rr_ptr    (rr_ptr),
    .req_valid (bus.req_valid),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // Mux the granted requester's record slices out of the flat buses.
  always_comb begin
    sel_rec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_rec.kind = kind_t'(bus.req_kind[2*i +: 2]);
        sel_rec.addr = bus.req_addr[5*i +: 5];
        sel_rec.data = bus.req_data[32*i +: 32];
      end
    end
  end

  // Frame FSM: accept in IDLE, stream bytes in SEND, hold off in GAP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      grant_id_q <= '0;
      byte_idx   <= '0;
      gap_cnt    <= '0;
      rec        <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            rec        <= sel_rec;
            grant_id_q <= grant_idx;
            rr_ptr     <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            byte_idx   <= '0;
            tx_data_q  <= SYNC_BYTE;
            tx_valid_q <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.tx_ready) begin
            if (byte_idx == IDX_W'(FRAME_LEN - 1)) begin
              tx_valid_q <= 1'b0;
              gap_cnt    <= '0;
              state      <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end else begin
              byte_idx  <= byte_idx + 1'b1;
              tx_data_q <= frame_byte(byte_idx + 1'b1, rec);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state <= ST_IDLE;
          else                                   gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (resetn && state == ST_IDLE) ? grant_oh : '0;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.grant_id  = grant_id_q;
endmodule

// File: tb/tb_uart_frame_arbiter.sv
// tb/tb_uart_frame_arbiter.sv - directed self-checking bench for uart_frame_arbiter
module tb_uart_frame_arbiter;
`ifdef UART_ARB_CHECKSUM_EN
  localparam int FLEN = 7;
`else
  localparam int FLEN = 6;
`endif

  logic clk = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] exp1 [7] = '{8'hA5, 8'h82, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h0B};
  logic [7:0] exp2 [7] = '{8'hA5, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h42};

  always #5 clk = ~clk;

  uart_frame_arbiter_if #(.NUM_REQ(4)) ia ();
  uart_frame_arbiter_if #(.NUM_REQ(3)) ib ();

  uart_frame_arbiter #(.NUM_REQ(4), .GAP_CYCLES(16)) u_dut_gap (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ia.slave)
  );

  uart_frame_arbiter #(.NUM_REQ(3), .GAP_CYCLES(0)) u_dut_rr (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ib.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int gap, cyc, idx, t, n, t_last;
    resetn = 1'b0;
    ia.req_valid = '0; ia.req_kind = '0; ia.req_addr = '0; ia.req_data = '0; ia.tx_ready = 1'b1;
    ib.req_valid = '0; ib.req_kind = '0; ib.req_addr = '0; ib.req_data = '0; ib.tx_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state, with a request pending that must not be acknowledged
    ia.req_valid = 4'b0001;
    #1;
    check("rst_tx_valid", ia.tx_valid, 1'b0);
    check("rst_tx_data", ia.tx_data, 8'h00);
    check("rst_req_ready", ia.req_ready, 4'b0000);
    check("rst_busy", ia.busy, 1'b0);
    check("rst_grant_id", ia.grant_id, 2'd0);
    check("rst_rr_busy", ib.busy, 1'b0);

    // Single request from requester 2
    @(negedge clk);
    resetn = 1'b1;
    ia.req_valid = 4'b0100;
    ia.req_kind[5:4]   = 2'b10;
    ia.req_addr[14:10] = 5'd1;
    ia.req_data[95:64] = 32'h8C010004;
    #1;
    check("f1_req_ready", ia.req_ready, 4'b0100);
    check("f1_idle_busy", ia.busy, 1'b0);
    @(negedge clk);
    ia.req_valid = '0;
    check("f1_ready_drop", ia.req_ready, 4'b0000);
    check("f1_busy", ia.busy, 1'b1);
    check("f1_grant_id", ia.grant_id, 2'd2);
    for (int i = 0; i < FLEN; i++) begin
      check($sformatf("f1_valid%0d", i), ia.tx_valid, 1'b1);
      check($sformatf("f1_byte%0d", i), ia.tx_data, exp1[i]);
      if (i == FLEN - 1) begin
        ia.req_valid = 4'b0001;
        ia.req_kind[1:0] = 2'b00;
        ia.req_addr[4:0] = 5'd3;
        ia.req_data[31:0] = 32'h11223344;
      end
      @(negedge clk);
    end

    // Inter-frame gap with the next request already waiting
    gap = 0;
    for (int i = 0; i < 40 && ia.busy && !ia.tx_valid; i++) begin
      gap++;
      @(negedge clk);
    end
    check("gap_len", gap, 16);
    check("gap_end_busy", ia.busy, 1'b0);
    check("gap_end_valid", ia.tx_valid, 1'b0);
    check("gap_wrap_ready", ia.req_ready, 4'b0001);
    @(negedge clk);
    ia.req_valid = '0;
    check("f2_grant_id", ia.grant_id, 2'd0);

    // tx_ready toggling: every byte shown twice, accepted on the second showing
    idx = 0;
    cyc = 0;
    while (ia.tx_valid && cyc < 40) begin
      check($sformatf("f2_byte%0d", idx), ia.tx_data, exp2[(idx < 7) ? idx : 0]);
      ia.tx_ready = (cyc % 2 == 1);
      if (ia.tx_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    ia.tx_ready = 1'b1;
    check("f2_cycles", cyc, 2 * FLEN);
    check("f2_bytes", idx, FLEN);

    // Reset in the middle of a frame from requester 1
    ia.req_valid = 4'b0010;
    ia.req_kind[3:2] = 2'b01;
    ia.req_addr[9:5] = 5'd2;
    ia.req_data[63:32] = 32'hDEADBEEF;
    t = 0;
    while (!ia.tx_valid && t < 60) begin
      t++;
      @(negedge clk);
    end
    ia.req_valid = '0;
    check("f3_start", ia.tx_valid, 1'b1);
    check("f3_sync", ia.tx_data, 8'hA5);
    check("f3_grant_id", ia.grant_id, 2'd1);
    repeat (3) @(negedge clk);
    check("f3_byte3", ia.tx_data, 8'hAD);
    resetn = 1'b0;
    #1;
    check("mid_rst_tx_valid", ia.tx_valid, 1'b0);
    check("mid_rst_tx_data", ia.tx_data, 8'h00);
    check("mid_rst_busy", ia.busy, 1'b0);
    check("mid_rst_grant_id", ia.grant_id, 2'd0);
    @(negedge clk);
    resetn = 1'b1;
    ia.req_valid = 4'b1010;
    ia.req_kind[7:6] = 2'b11;
    ia.req_addr[19:15] = 5'd7;
    ia.req_data[127:96] = 32'h0;
    #1;
    check("post_rst_ptr0", ia.req_ready, 4'b0010);
    @(negedge clk);
    ia.req_valid = '0;
    check("post_rst_valid", ia.tx_valid, 1'b1);
    check("post_rst_sync", ia.tx_data, 8'hA5);
    check("post_rst_grant_id", ia.grant_id, 2'd1);

    // Three requesters held valid, no gap: 0,1,2,0,1 every FLEN+1 clocks
    ib.req_valid = 3'b111;
    ib.req_kind  = 6'b10_01_00;
    ib.req_addr  = 15'h1234;
    ib.req_data  = {32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    #1;
    n = 0;
    t_last = 0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      if (ib.req_ready != '0) begin
        check($sformatf("rr_grant%0d", n), ib.req_ready, 3'b001 << (n % 3));
        if (n > 0) check($sformatf("rr_spacing%0d", n), c - t_last, FLEN + 1);
        t_last = c;
        n++;
      end
      @(negedge clk);
    end
    check("rr_count", n, 5);
    ib.req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
